// File: rtl/weaksoc_bus_arbiter.sv
// Two-master round-robin arbiter for the weaksoc req/ack bus, one transaction in flight.
// Optional slave timeout enabled by WEAKSOC_ARB_TIMEOUT_EN.
module weaksoc_bus_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [3:0]  m0_wr_mask,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_out,
    output logic [31:0] m0_in,
    output logic        m0_ack,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [3:0]  m1_wr_mask,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_out,
    output logic [31:0] m1_in,
    output logic        m1_ack,
    output logic        s_req,
    output logic        s_wr,
    output logic [3:0]  s_wr_mask,
    output logic [31:0] s_addr,
    output logic [31:0] s_out,
    input  logic [31:0] s_in,
    input  logic        s_ack,
    output logic [1:0]  grant,
    output logic        timeout_err
);
    typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

    state_t state, state_nxt;
    logic   last;
    logic   sel;
    logic   done;
    logic   to_hit;

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("TIMEOUT out of range 1..65535");
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            if (done || to_hit)
                last <= sel;
        end
    end

`ifdef WEAKSOC_ARB_TIMEOUT_EN
    logic [15:0] cnt;

    // Counter sits at zero in IDLE, so it is already clear on the first BUSY cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == IDLE)
                cnt <= '0;
            else if (!s_ack)
                cnt <= cnt + 16'd1;
            if (to_hit)
                timeout_err <= 1'b1;
        end
    end

    assign to_hit = (state != IDLE) && (sel ? m1_req : m0_req) && !s_ack &&
                    (cnt == 16'(TIMEOUT - 1));
`else
    assign to_hit      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        sel       = (state == BUSY1);
        grant     = 2'b00;
        s_req     = 1'b0;
        s_wr      = 1'b0;
        s_wr_mask = 4'h0;
        s_addr    = 32'h0;
        s_out     = 32'h0;
        m0_ack    = 1'b0;
        m1_ack    = 1'b0;
        m0_in     = 32'h0;
        m1_in     = 32'h0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                // Tie goes to whichever master was not served last.
                if (m0_req && m1_req)
                    state_nxt = last ? BUSY0 : BUSY1;
                else if (m0_req)
                    state_nxt = BUSY0;
                else if (m1_req)
                    state_nxt = BUSY1;
            end
            BUSY0, BUSY1: begin
                grant     = sel ? 2'b10 : 2'b01;
                s_req     = (sel ? m1_req : m0_req) && !to_hit;
                s_wr      = sel ? m1_wr      : m0_wr;
                s_wr_mask = sel ? m1_wr_mask : m0_wr_mask;
                s_addr    = sel ? m1_addr    : m0_addr;
                s_out     = sel ? m1_out     : m0_out;
                done      = s_req && s_ack;
                // A dropped request (abort) also returns to IDLE, without an ack.
                if (!(sel ? m1_req : m0_req) || done || to_hit)
                    state_nxt = IDLE;
                if (sel) begin
                    m1_ack = done || to_hit;
                    m1_in  = to_hit ? 32'hFFFF_FFFF : (s_ack ? s_in : 32'h0);
                end else begin
                    m0_ack = done || to_hit;
                    m0_in  = to_hit ? 32'hFFFF_FFFF : (s_ack ? s_in : 32'h0);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: doc/weaksoc_bus_arbiter.md
Name: weaksoc_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the weaksoc system bus (req/ack, wr, 4-bit byte write mask, 32-bit addr/data).
- Lets weakcore (m0) and a second master (m1: DMA or debug) share the peripheral decode/BROM/LED fabric.
- Sits between the masters and the existing peripheral-select logic.
- Arbitration: round-robin, one outstanding transaction, grant held until slave ack.

Parameters:
- TIMEOUT, 255: busy cycles without s_ack before forced completion (only with WEAKSOC_ARB_TIMEOUT_EN); legal range 1..65535.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- m0_req / m1_req  in  1  master requests; held with addr/data stable until ack
- m0_wr / m1_wr  in  1  1 = write, 0 = read
- m0_wr_mask / m1_wr_mask  in  4  byte write enables
- m0_addr / m1_addr  in  32  byte address
- m0_out / m1_out  in  32  write data from master
- m0_in / m1_in  out  32  read data to master
- m0_ack / m1_ack  out  1  one-cycle completion pulse
- s_req  out  1  request to slave fabric
- s_wr  out  1  write flag to slave fabric
- s_wr_mask  out  4  byte write enables to slave fabric
- s_addr  out  32  address to slave fabric
- s_out  out  32  write data to slave fabric
- s_in  in  32  slave read data
- s_ack  in  1  slave completion, valid only while s_req=1
- grant  out  2  one-hot current owner (01 = m0, 10 = m1, 00 = none)
- timeout_err  out  1  sticky timeout flag

Behaviour:
- States: IDLE, BUSY0, BUSY1 (registered). Register `last` holds the index of the last master served.
- Reset (rst=0, async): state=IDLE, last=1 (so m0 wins the first tie), timeout counter=0, timeout_err=0. All outputs 0 immediately. Reset mid-transaction drops it silently; no ack is issued.
- IDLE: grant=00, all s_* outputs 0, both acks 0.
  - Only mX_req=1: next state BUSYX.
  - Both req=1: grant the master != last.
  - Neither: stay IDLE.
- Arbitration latency: 1 cycle. A request seen in IDLE drives the slave from the next cycle.
- BUSYX: grant one-hot X. s_req/s_wr/s_wr_mask/s_addr/s_out are driven combinationally from master X.
  - mX_in = s_in when s_ack, else 0.
  - mX_ack = s_req & s_ack, same cycle as s_ack (zero added latency on the return path).
  - Non-granted master: ack=0, in=0.
- Completion (s_ack=1 in BUSYX): last <= X, next state IDLE.
  - One IDLE cycle always separates transactions, so back-to-back throughput is at most 1 transaction per 2 cycles.
- Abort: mX_req drops to 0 in BUSYX before ack. s_req follows to 0, no ack is issued, next state IDLE, last unchanged.
- s_ack while s_req=0 (IDLE): ignored.
- Requests arriving in the same cycle as a completion: not granted that cycle; they are arbitrated in the following IDLE cycle with the updated `last`.

Optional Feature:
- Macro: WEAKSOC_ARB_TIMEOUT_EN.
- With the macro:
  - A 16-bit counter clears on entry to BUSYX and increments each BUSYX cycle with s_ack=0.
  - In the cycle where counter == TIMEOUT-1 and s_ack=0: mX_ack=1, mX_in=32'hFFFFFFFF, s_req=0, timeout_err<=1, next state IDLE, last<=X.
  - timeout_err is sticky until reset.
- Without the macro: no counter, timeout_err tied 0, a slave that never acks stalls the bus indefinitely.

Test Plan:
- m0 read addr 0x00000004 only, slave acks immediately with 0x12345678 -> s_req=1 and s_addr=0x4 in cycle 1, m0_ack=1 and m0_in=0x12345678 in cycle 1, grant=00 in cycle 2.
- Both masters request continuously, slave always acks -> grant sequence 01,00,10,00,01...; each master gets one ack every 4 cycles; m0 served first after reset.
- m1 write addr 0x80000000, data 0x1, mask 0001, slave acks after 3 wait cycles; m0_req rises during the wait -> s_* stable for all 4 cycles, m1_ack pulses once, m0 granted 2 cycles after m1_ack.
- rst pulled low during BUSY1 -> all outputs 0 in the same cycle, no m1_ack; after release with both requesting, m0 granted first.
- m0 drops req after 1 cycle in BUSY0 with no s_ack -> no m0_ack, return to IDLE, last unchanged (next tie goes to m0).
- TIMEOUT=8 with the macro, slave never acks, m1 read -> m1_ack on the 8th BUSY1 cycle with m1_in=0xFFFFFFFF, timeout_err=1 and stays 1 until rst; without the macro, no ack after 100 cycles and timeout_err=0.
